// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column partial-sum output FIFOs that realign skewed PE-array
// columns into complete rows. Each column fills at its own rate; a row is popped
// only when every column holds at least one entry. Reads are first-word-fall-
// through from distributed storage.
// Optional feature: define PSUM_OFIFO_OVF_EN to add the sticky o_ovf flag that
// records any write dropped because its column was full.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready
`ifdef PSUM_OFIFO_OVF_EN
  ,
  output logic                   o_ovf
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [col-1:0] col_nonempty;
  logic [col-1:0] col_full;
  logic [col-1:0] wr_acc;
  logic           rd_acc;

  // Row-level status depends only on the occupancy counts.
  assign o_valid = &col_nonempty;
  assign o_full  = |col_full;
  assign o_ready = ~o_full;

  // A pop is honoured only when a complete row is present.
  assign rd_acc = rd & o_valid;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_col
      logic [psum_bw-1:0] mem_q [depth];
      logic [AW-1:0]      wr_ptr_q;
      logic [AW-1:0]      wr_ptr_d;
      logic [AW-1:0]      rd_ptr_q;
      logic [AW-1:0]      rd_ptr_d;
      logic [CW-1:0]      count_q;
      logic [CW-1:0]      count_d;

      assign col_nonempty[gi] = (count_q != '0);
      assign col_full[gi]     = (count_q == DEPTH_C);
      // A full column can still take a write when the same cycle pops a row.
      assign wr_acc[gi]       = wr[gi] & (~col_full[gi] | rd_acc);
      assign out[psum_bw*gi +: psum_bw] = mem_q[rd_ptr_q];

      // Next-state pointers and occupancy for this column.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc[gi]) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc[gi] && !rd_acc) begin
          count_d = count_q + CW'(1);
        end else if (!wr_acc[gi] && rd_acc) begin
          count_d = count_q - CW'(1);
        end
      end

      // Pointer and count registers; reset empties the column.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage write; contents are left untouched by reset.
      always_ff @(posedge clk) begin
        if (wr_acc[gi]) begin
          mem_q[wr_ptr_q] <= in[psum_bw*gi +: psum_bw];
        end
      end
    end
  endgenerate

`ifdef PSUM_OFIFO_OVF_EN
  logic [col-1:0] drop;
  logic           ovf_q;
  logic           ovf_d;

  assign drop  = wr & col_full & {col{~rd_acc}};
  assign o_ovf = ovf_q;

  // Sticky overflow: any dropped write sets it until the next reset.
  always_comb begin
    ovf_d = ovf_q | (|drop);
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_psum_ofifo.sv
// Testbench for psum_ofifo: directed scenarios plus a randomized phase, all
// checked against a queue-per-column reference model.
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 16;
  localparam int W     = COL * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_v;
  logic [COL-1:0] wr_v;
  logic           rd_v;
  logic [W-1:0]   out_v;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
`ifdef PSUM_OFIFO_OVF_EN
  logic           o_ovf;
`endif

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_v),
    .wr      (wr_v),
    .rd      (rd_v),
    .out     (out_v),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready)
`ifdef PSUM_OFIFO_OVF_EN
    ,
    .o_ovf   (o_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one queue per column plus the sticky overflow bit.
  logic [BW-1:0] mq [COL][$];
  bit            ovf_m;
  int            checks = 0;
  int            errors = 0;

  function automatic bit m_valid();
    for (int i = 0; i < COL; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < COL; i++) if (mq[i].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] m_row();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = mq[i][0];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < COL; i++) mq[i].delete();
    ovf_m = 1'b0;
  endtask

  task automatic model_edge(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    bit racc;
    bit was_full;
    racc = r && m_valid();
    for (int i = 0; i < COL; i++) begin
      was_full = (mq[i].size() == DEPTH);
      if (racc) void'(mq[i].pop_front());
      if (w[i]) begin
        if (!was_full || racc) mq[i].push_back(d[i*BW +: BW]);
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, W'(o_valid), W'(m_valid()));
    chk({tag, "_full"},  W'(o_full),  W'(m_full()));
    chk({tag, "_ready"}, W'(o_ready), W'(!m_full()));
    if (m_valid()) chk({tag, "_out"}, out_v, m_row());
`ifdef PSUM_OFIFO_OVF_EN
    chk({tag, "_ovf"}, W'(o_ovf), W'(ovf_m));
`endif
  endtask

  // One clock transaction: drive, advance the model at the edge, check after it.
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r, input string tag);
    wr_v = w;
    in_v = d;
    rd_v = r;
    @(posedge clk);
    model_edge(w, d, r);
    #1;
    $display("%0t %s wr=%h rd=%0d valid=%0d full=%0d out=%h", $time, tag, w, r, o_valid, o_full, out_v);
    check_outputs(tag);
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  function automatic logic [W-1:0] tag_row(input int base, input int k);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + (i << 12) + k);
    return r;
  endfunction

  function automatic logic [W-1:0] wrap_row(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(k * COL + i);
    return r;
  endfunction

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] expect_row;
    wr_v  = '0;
    in_v  = '0;
    rd_v  = 1'b0;
    reset = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #2 check_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_outputs("post_reset");

    // One full row written in a single cycle.
    d = '0;
    for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'((i + 1) * 16'h11);
    step(8'hFF, d, 1'b0, "row_all");
    expect_row = 128'h0088_0077_0066_0055_0044_0033_0022_0011;
    chk("row_all_valid", W'(o_valid), W'(1));
    chk("row_all_out", out_v, expect_row);
    step(8'h00, '0, 1'b1, "row_pop");
    chk("row_pop_valid", W'(o_valid), W'(0));

    // Skewed columns: one column per cycle.
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(16'h0100 + i);
      step(COL'(1 << i), d, 1'b0, "skew");
      chk("skew_valid", W'(o_valid), W'(i == COL - 1));
    end
    for (int i = 0; i < COL; i++) expect_row[i*BW +: BW] = BW'(16'h0100 + i);
    chk("skew_row", out_v, expect_row);
    step(8'h00, '0, 1'b1, "skew_pop");
    chk("skew_pop_valid", W'(o_valid), W'(0));

    // Fill column 3, then overflow it.
    for (int k = 0; k < DEPTH; k++) step(8'h08, tag_row(0, k), 1'b0, "fill3");
    chk("fill3_full", W'(o_full), W'(1));
    chk("fill3_ready", W'(o_ready), W'(0));
    d = '0;
    d[3*BW +: BW] = 16'hDEAD;
    step(8'h08, d, 1'b0, "drop3");
`ifdef PSUM_OFIFO_OVF_EN
    chk("ovf_set", W'(o_ovf), W'(1));
`endif
    step(8'h00, '0, 1'b0, "idle");
`ifdef PSUM_OFIFO_OVF_EN
    chk("ovf_sticky", W'(o_ovf), W'(1));
`endif

    // Fill the remaining columns, then pop and push together while full.
    for (int k = 0; k < DEPTH; k++) step(8'hF7, tag_row(0, k), 1'b0, "fill_rest");
    chk("all_full_row", out_v, tag_row(0, 0));
    step(8'hFF, tag_row(16'h0A00, 0), 1'b1, "full_rdwr");
    chk("full_rdwr_full", W'(o_full), W'(1));
    for (int k = 0; k < DEPTH; k++) step(8'h00, '0, 1'b1, "drain");
    chk("drain_valid", W'(o_valid), W'(0));

    // Pop request with column 5 empty must be ignored.
    step(8'hDF, rnd_row(), 1'b0, "no5_a");
    step(8'hDF, rnd_row(), 1'b0, "no5_b");
    step(8'h00, '0, 1'b1, "rd_ignored");
    chk("rd_ignored_valid", W'(o_valid), W'(0));
    step(8'h20, rnd_row(), 1'b0, "col5_a");
    step(8'h20, rnd_row(), 1'b0, "col5_b");
    step(8'h00, '0, 1'b1, "col5_pop_a");
    step(8'h00, '0, 1'b1, "col5_pop_b");
    chk("col5_empty", W'(o_valid), W'(0));

    // Wrap-around streaming of 40 incrementing rows.
    step(8'hFF, wrap_row(0), 1'b0, "wrap_in");
    for (int k = 1; k < 40; k++) begin
      chk("wrap_out", out_v, wrap_row(k - 1));
      step(8'hFF, wrap_row(k), 1'b1, "wrap");
    end
    chk("wrap_last", out_v, wrap_row(39));
    step(8'h00, '0, 1'b1, "wrap_end");

    // Randomized traffic: write-heavy then read-heavy.
    for (int n = 0; n < 300; n++) begin
      logic [COL-1:0] w;
      logic r;
      if (n < 150) begin
        w = COL'($urandom) | COL'($urandom);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = COL'($urandom) & COL'($urandom);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, rnd_row(), r, "rand");
    end

    // Reset in the middle of a stream clears status without a clock edge.
    step(8'hFF, rnd_row(), 1'b0, "pre_reset");
    chk("pre_reset_valid", W'(o_valid), W'(1));
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_valid", W'(o_valid), W'(0));
    check_outputs("async_reset");
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    reset = 1'b0;
    step(8'hFF, wrap_row(7), 1'b0, "after_reset");
    chk("after_reset_out", out_v, wrap_row(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
